// File: rtl/addr_gen_pkg.sv
// Shared definitions for the address generator: mode encoding and default sizes.
package addr_gen_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_STRIDE_W = 8;

  typedef enum logic [1:0] {
    MODE_FREE = 2'b00,
    MODE_WRAP = 2'b01,
    MODE_SAT  = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

endpackage : addr_gen_pkg

// File: rtl/addr_gen_if.sv
// Control/address bus between a sequencer (master) and the address generator (slave).
interface addr_gen_if
  import addr_gen_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int STRIDE_W = DEF_STRIDE_W
) ();

  logic                load;
  logic [WIDTH-1:0]    load_val;
  logic                inc_en;
  logic [STRIDE_W-1:0] stride;
  logic [WIDTH-1:0]    limit;
  logic [1:0]          mode;
  logic [WIDTH-1:0]    addr;
  logic                wrapped;
  logic                done;
  logic                at_limit;

  modport master (
    output load, load_val, inc_en, stride, limit, mode,
    input  addr, wrapped, done, at_limit
  );

  modport slave (
    input  load, load_val, inc_en, stride, limit, mode,
    output addr, wrapped, done, at_limit
  );

endinterface : addr_gen_if

// File: rtl/addr_gen.sv
// Address generator: loadable start address, stride increment, and
// free-running / wrap-to-base / saturate-at-limit / hold modes.
module addr_gen
  import addr_gen_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int STRIDE_W = DEF_STRIDE_W
) (
  input  logic        clk,
  input  logic        rst,
  addr_gen_if.slave   bus
);

  // Power-up value so addr reads 0 even before the first reset.
  logic [WIDTH-1:0] r_addr    = '0;
  logic [WIDTH-1:0] r_base    = '0;
  logic             r_wrapped = 1'b0;
  logic             r_done    = 1'b0;

  logic [WIDTH:0]   w_next;
  logic             w_over_limit;
  logic             w_carry;
  logic             w_step;

  // One extra bit keeps the carry out so FREE overflow and the limit
  // compare are both exact.
  assign w_next       = {1'b0, r_addr} + {{(WIDTH + 1 - STRIDE_W){1'b0}}, bus.stride};
  assign w_carry      = w_next[WIDTH];
  assign w_over_limit = (w_next > {1'b0, bus.limit});
  assign w_step       = bus.inc_en && (bus.stride != '0) && (bus.mode != MODE_HOLD);

  // Address, base and flag registers; rst beats load beats increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_base    <= '0;
      r_wrapped <= 1'b0;
      r_done    <= 1'b0;
    end else if (bus.load) begin
      r_addr    <= bus.load_val;
      r_base    <= bus.load_val;
      r_wrapped <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // The wrap pulse lasts exactly one cycle unless re-armed below.
      r_wrapped <= 1'b0;
      if (w_step) begin
        case (bus.mode)
          MODE_FREE: begin
            r_addr <= w_next[WIDTH-1:0];
            if (w_carry) begin
              r_wrapped <= 1'b1;
              r_done    <= 1'b1;
            end
          end
          MODE_WRAP: begin
            // A limit below base simply wraps on every step; not flagged.
            if (w_over_limit) begin
              r_addr    <= r_base;
              r_wrapped <= 1'b1;
              r_done    <= 1'b1;
            end else begin
              r_addr <= w_next[WIDTH-1:0];
            end
          end
          MODE_SAT: begin
            if (w_over_limit) begin
              r_addr <= bus.limit;
              r_done <= 1'b1;
            end else begin
              r_addr <= w_next[WIDTH-1:0];
            end
          end
          default: begin
            r_addr <= r_addr;
          end
        endcase
      end
    end
  end

  assign bus.addr     = r_addr;
  assign bus.wrapped  = r_wrapped;
  assign bus.done     = r_done;
  assign bus.at_limit = (r_addr == bus.limit);

endmodule : addr_gen

// File: tb/tb_addr_gen.sv
// Directed and randomized checks of addr_gen against an arithmetic reference model.
module tb_addr_gen;

  localparam int W  = 8;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  addr_gen_if #(.WIDTH(W), .STRIDE_W(SW)) bus ();

  addr_gen #(.WIDTH(W), .STRIDE_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, plain integers.
  int m_addr    = 0;
  int m_base    = 0;
  bit m_wrapped = 1'b0;
  bit m_done    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // What one rising edge does, from the behavioural rules.
  task automatic model_edge();
    int n;
    if (rst) begin
      m_addr = 0; m_base = 0; m_wrapped = 0; m_done = 0;
    end else if (bus.load) begin
      m_addr = int'(bus.load_val); m_base = m_addr; m_wrapped = 0; m_done = 0;
    end else begin
      m_wrapped = 0;
      if (bus.inc_en && bus.stride != 0 && bus.mode != 2'b11) begin
        n = m_addr + int'(bus.stride);
        if (bus.mode == 2'b00) begin
          if (n >= 256) begin m_wrapped = 1; m_done = 1; end
          m_addr = n % 256;
        end else if (bus.mode == 2'b01) begin
          if (n > int'(bus.limit)) begin m_addr = m_base; m_wrapped = 1; m_done = 1; end
          else m_addr = n;
        end else begin
          if (n > int'(bus.limit)) begin m_addr = int'(bus.limit); m_done = 1; end
          else m_addr = n;
        end
      end
    end
  endtask

  task automatic drive(input bit r, input bit ld, input int lv, input bit inc,
                       input int st, input int lim, input int md);
    rst          = r;
    bus.load     = ld;
    bus.load_val = lv[W-1:0];
    bus.inc_en   = inc;
    bus.stride   = st[SW-1:0];
    bus.limit    = lim[W-1:0];
    bus.mode     = md[1:0];
  endtask

  // Clock one edge, update the model, then sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".addr"},     32'(bus.addr),     32'(m_addr));
    chk({tag, ".wrapped"},  32'(bus.wrapped),  32'(m_wrapped));
    chk({tag, ".done"},     32'(bus.done),     32'(m_done));
    chk({tag, ".at_limit"}, 32'(bus.at_limit), 32'(m_addr == int'(bus.limit)));
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 8'hFF, 0);
    #1;
    chk("pre_reset.addr", 32'(bus.addr), 32'd0);

    // Reset, then FREE count by 1.
    drive(1, 0, 0, 1, 1, 8'hFF, 0);
    tick();
    chk("rst.addr", 32'(bus.addr), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    drive(0, 0, 0, 1, 1, 8'hFF, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("free%0d.addr", i), 32'(bus.addr), 32'(i));
      chk($sformatf("free%0d.wrapped", i), 32'(bus.wrapped), 32'd0);
      chk($sformatf("free%0d.done", i), 32'(bus.done), 32'd0);
    end

    // FREE overflow from FE by 3.
    drive(0, 1, 8'hFE, 0, 3, 8'hFF, 0);
    tick();
    chk("ovf_load.addr", 32'(bus.addr), 32'hFE);
    drive(0, 0, 0, 1, 3, 8'hFF, 0);
    tick();
    chk("ovf.addr", 32'(bus.addr), 32'h01);
    chk("ovf.wrapped", 32'(bus.wrapped), 32'd1);
    chk("ovf.done", 32'(bus.done), 32'd1);
    drive(0, 0, 0, 0, 3, 8'hFF, 0);
    tick();
    chk("ovf_after.wrapped", 32'(bus.wrapped), 32'd0);
    chk("ovf_after.done", 32'(bus.done), 32'd1);

    // WRAP: 10 -> 14, 18, 10.
    drive(0, 1, 10, 0, 4, 20, 1);
    tick();
    chk("wrap_load.done", 32'(bus.done), 32'd0);
    drive(0, 0, 0, 1, 4, 20, 1);
    tick();
    chk("wrap1.addr", 32'(bus.addr), 32'd14);
    chk("wrap1.wrapped", 32'(bus.wrapped), 32'd0);
    chk("wrap1.at_limit", 32'(bus.at_limit), 32'd0);
    tick();
    chk("wrap2.addr", 32'(bus.addr), 32'd18);
    chk("wrap2.wrapped", 32'(bus.wrapped), 32'd0);
    chk("wrap2.at_limit", 32'(bus.at_limit), 32'd0);
    tick();
    chk("wrap3.addr", 32'(bus.addr), 32'd10);
    chk("wrap3.wrapped", 32'(bus.wrapped), 32'd1);
    chk("wrap3.done", 32'(bus.done), 32'd1);
    chk("wrap3.at_limit", 32'(bus.at_limit), 32'd0);

    // SAT: 10 -> 14, 18, 20, 20.
    drive(0, 1, 10, 0, 4, 20, 2);
    tick();
    drive(0, 0, 0, 1, 4, 20, 2);
    tick();
    chk("sat1.addr", 32'(bus.addr), 32'd14);
    chk("sat1.done", 32'(bus.done), 32'd0);
    tick();
    chk("sat2.addr", 32'(bus.addr), 32'd18);
    chk("sat2.done", 32'(bus.done), 32'd0);
    tick();
    chk("sat3.addr", 32'(bus.addr), 32'd20);
    chk("sat3.done", 32'(bus.done), 32'd1);
    chk("sat3.at_limit", 32'(bus.at_limit), 32'd1);
    chk("sat3.wrapped", 32'(bus.wrapped), 32'd0);
    tick();
    chk("sat4.addr", 32'(bus.addr), 32'd20);
    chk("sat4.done", 32'(bus.done), 32'd1);
    chk("sat4.wrapped", 32'(bus.wrapped), 32'd0);

    // load and inc together: load wins; then a zero-stride inc.
    drive(0, 1, 5, 1, 4, 20, 0);
    tick();
    chk("ldinc.addr", 32'(bus.addr), 32'd5);
    chk("ldinc.done", 32'(bus.done), 32'd0);
    drive(0, 0, 0, 1, 0, 20, 0);
    tick();
    chk("stride0.addr", 32'(bus.addr), 32'd5);

    // HOLD mode leaves addr alone.
    drive(0, 0, 0, 1, 7, 20, 3);
    tick();
    chk("hold.addr", 32'(bus.addr), 32'd5);

    // Get done set, then rst with inc_en high.
    drive(0, 0, 0, 1, 1, 5, 2);
    tick();
    chk("sat_at_lim.addr", 32'(bus.addr), 32'd5);
    chk("sat_at_lim.done", 32'(bus.done), 32'd1);
    drive(1, 0, 0, 1, 1, 5, 2);
    tick();
    chk("rst_done.addr", 32'(bus.addr), 32'd0);
    chk("rst_done.done", 32'(bus.done), 32'd0);
    chk("rst_done.wrapped", 32'(bus.wrapped), 32'd0);

    // A wrapping increment coincident with rst leaves no pulse behind.
    drive(0, 1, 8'hFE, 0, 3, 8'hFF, 0);
    tick();
    drive(1, 0, 0, 1, 3, 8'hFF, 0);
    tick();
    chk("rst_ovf.wrapped", 32'(bus.wrapped), 32'd0);
    chk("rst_ovf.addr", 32'(bus.addr), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0), $urandom_range(0, 255),
            ($urandom_range(0, 9) < 8), $urandom_range(0, 15),
            ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255),
            $urandom_range(0, 3));
      tick();
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_addr_gen

// File: doc/addr_gen.md
ADDR_GEN -- requirements
Module: addr_gen

Interface
REQ-001 Parameter WIDTH, default 32, width of the address, base and limit.
REQ-002 Parameter STRIDE_W, default 8, width of the stride input.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 load  input  1  loads load_val into addr and base.
REQ-006 load_val  input  WIDTH  start address and wrap target.
REQ-007 inc_en  input  1  advances addr by stride this cycle.
REQ-008 stride  input  STRIDE_W  increment, zero-extended to WIDTH+1.
REQ-009 limit  input  WIDTH  inclusive upper bound for WRAP and SAT modes.
REQ-010 mode  input  2  00 FREE, 01 WRAP, 10 SAT, 11 HOLD.
REQ-011 addr  output  WIDTH  current address, registered, drives the address bus.
REQ-012 wrapped  output  1  one-cycle pulse on the cycle after a wrap or overflow.
REQ-013 done  output  1  sticky end-of-range flag.
REQ-014 at_limit  output  1  combinational, addr == limit.

Function
REQ-015 Priority per edge: rst > load > inc_en; lower-priority requests in the same cycle are discarded.
REQ-016 load: addr <= load_val, base <= load_val, done <= 0, wrapped <= 0.
REQ-017 inc_en with stride == 0 or mode == HOLD: addr, done unchanged; wrapped <= 0.
REQ-018 Otherwise next = {1'b0,addr} + stride, computed at WIDTH+1 bits.
REQ-019 FREE: addr <= next[WIDTH-1:0]; limit ignored; on next[WIDTH] == 1, wrapped <= 1 and done <= 1.
REQ-020 WRAP: if next > {1'b0,limit}, addr <= base, wrapped <= 1, done <= 1; else addr <= next.
REQ-021 SAT: if next > {1'b0,limit}, addr <= limit, done <= 1, wrapped <= 0; else addr <= next.
REQ-022 SAT with addr == limit and inc_en: addr holds, done stays 1, no pulse.
REQ-023 wrapped is 0 in every cycle not covered by REQ-019/REQ-020.
REQ-024 Latency: addr reflects an inc_en or load one clock after the sampling edge; no combinational path from inputs to addr.
REQ-025 Mode or limit changes take effect on the next inc_en; no retroactive correction of addr.
REQ-026 limit < base in WRAP mode: each increment wraps to base; the block does not detect or flag this condition.
REQ-027 done is cleared only by rst or load.

Reset
REQ-028 rst: addr = 0, base = 0, wrapped = 0, done = 0 on the next rising edge.
REQ-029 rst mid-sequence aborts the sequence; no pending wrap pulse survives reset.
REQ-030 Before the first rst, addr is 0.

Structure
REQ-031 Package addr_gen_pkg holds the mode encoding (FREE/WRAP/SAT/HOLD) and the default WIDTH and STRIDE_W constants.
REQ-032 Single flat module; the next-address adder and compare stay inline, and no sub-module is required.
REQ-033 State is limited to the addr, base, wrapped and done registers.

Verification (WIDTH=8, STRIDE_W=4)
REQ-034 rst=1 for 1 cycle, then inc_en=1, stride=1, mode=FREE for 3 cycles -> addr 0,1,2,3; wrapped=0, done=0.
REQ-035 load 8'hFE, FREE, stride=3, one inc -> addr=8'h01, wrapped pulses 1 cycle, done=1.
REQ-036 load 10, limit=20, WRAP, stride=4 -> addr 14,18,10; wrapped=1 only on the cycle addr=10; at_limit never 1.
REQ-037 load 10, limit=20, SAT, stride=4 -> addr 14,18,20,20; done=1 from 20; at_limit=1; wrapped stays 0.
REQ-038 load=1 and inc_en=1 in the same cycle with load_val=5 -> addr=5, done=0; a following stride=0 inc leaves addr=5.
REQ-039 rst asserted with done=1 and inc_en=1 -> next cycle addr=0, done=0, wrapped=0.
